// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, credit-limited imem requests, PC tag queue and instruction FIFO.
// Define FETCH_PERF_CNT_EN to add the saturating perf_stall_cnt output.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(IBUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t           state, state_nxt;
    logic             drop_resp;
    logic             req_accept;
    logic             resp_keep;
    logic             tag_push;
    logic             fifo_pop;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard_cnt;
    logic [CNT_W-1:0] discard_new;
    logic [CNT_W:0]   credit_used;

    logic [31:0]      tag_q     [IBUF_DEPTH];
    logic [PTR_W-1:0] tag_wr, tag_rd;
    logic [31:0]      fifo_data [IBUF_DEPTH];
    logic [31:0]      fifo_pc   [IBUF_DEPTH];
    logic [PTR_W-1:0] fifo_wr, fifo_rd;
    logic [CNT_W-1:0] fifo_cnt;

    assign imem_req_addr  = pc_in;
    assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_cnt};
    assign imem_req_valid = !rst && (credit_used < (CNT_W + 1)'(IBUF_DEPTH));
    assign req_accept     = imem_req_valid && imem_req_ready;

    // Stale requests at redirect: everything in flight plus this cycle's accept, minus this cycle's response.
    assign discard_new = outstanding + CNT_W'(req_accept) - CNT_W'(imem_resp_valid);

    assign resp_keep  = imem_resp_valid && !drop_resp;
    assign tag_push   = req_accept && !redirect_valid;
    assign inst_valid = !rst && (fifo_cnt != '0);
    assign fifo_pop   = inst_valid && inst_ready && !redirect_valid;
    assign inst_data  = fifo_data[fifo_rd];
    assign inst_pc    = fifo_pc[fifo_rd];

    always_comb begin
        pc_next = pc_in;
        if (rst)
            pc_next = RESET_PC;
        else if (redirect_valid)
            pc_next = redirect_pc;
        else if (req_accept)
            pc_next = pc_in + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (redirect_valid && discard_new != '0)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (redirect_valid)
                    state_nxt = (discard_new != '0) ? DRAIN : RUN;
                else if (imem_resp_valid && discard_cnt == CNT_W'(1))
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        drop_resp = redirect_valid || (state == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(req_accept) - CNT_W'(imem_resp_valid);
            if (redirect_valid)
                discard_cnt <= discard_new;
            else if (state == DRAIN && imem_resp_valid)
                discard_cnt <= discard_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (tag_push)
            tag_q[tag_wr] <= pc_in;
        if (resp_keep) begin
            fifo_data[fifo_wr] <= imem_resp_data;
            fifo_pc[fifo_wr]   <= tag_q[tag_rd];
        end
    end

    // Redirect flushes both queues in the same cycle; the redirect-cycle accept is stale and not tagged.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            tag_wr   <= '0;
            tag_rd   <= '0;
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (tag_push)
                tag_wr <= tag_wr + PTR_W'(1);
            if (resp_keep) begin
                tag_rd  <= tag_rd + PTR_W'(1);
                fifo_wr <= fifo_wr + PTR_W'(1);
            end
            if (fifo_pop)
                fifo_rd <= fifo_rd + PTR_W'(1);
            fifo_cnt <= fifo_cnt + CNT_W'(resp_keep) - CNT_W'(fifo_pop);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            perf_stall_cnt <= '0;
        else if (imem_req_valid && !imem_req_ready && perf_stall_cnt != '1)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif

endmodule
